// File: rtl/uart_response_serializer.sv
// Serializes a 1-4 byte response word MSB first into the UART TX FIFO, honouring back-pressure with a stall timeout.
// RESPONSE_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module uart_response_serializer #(
   parameter int unsigned STALL_TIMEOUT = 1023,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   word_valid,
   output logic                   word_ready,
   input  logic [31:0]            word_data,
   input  logic [1:0]             word_bytes_m1,
   input  logic                   uart_tx_full,
   output logic                   uart_write,
   output logic [7:0]             uart_data,
   output logic                   busy,
   output logic                   stall_error,
   input  logic                   error_clear,
   output logic [COUNT_WIDTH-1:0] frame_count
);
   localparam int SW = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SEND, CHKSUM} state_t;

   state_t        state_q;
   logic [31:0]   shift_q;
   logic [1:0]    cnt_q;
   logic [SW-1:0] stall_q;
   logic [7:0]    last_q;
   logic          sending;
   logic          timeout;
`ifdef RESPONSE_CHECKSUM_EN
   logic [7:0]    xor_q;
`endif

   assign sending    = (state_q == SEND) || (state_q == CHKSUM);
   assign uart_write = sending && !uart_tx_full;
   // Fires on the cycle whose stall would bring the count to STALL_TIMEOUT.
   assign timeout    = (STALL_TIMEOUT != 0) && (stall_q == SW'(STALL_TIMEOUT - 1));

   always_comb begin
      uart_data = last_q;
      if (state_q == SEND) begin
         uart_data = shift_q[31:24];
      end
`ifdef RESPONSE_CHECKSUM_EN
      else if (state_q == CHKSUM) begin
         uart_data = xor_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         word_ready  <= 1'b1;
         busy        <= 1'b0;
         stall_error <= 1'b0;
         frame_count <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         stall_q     <= '0;
         last_q      <= '0;
`ifdef RESPONSE_CHECKSUM_EN
         xor_q       <= '0;
`endif
      end else begin
         if (error_clear) begin
            stall_error <= 1'b0;
         end
         if (uart_write) begin
            last_q  <= uart_data;
            stall_q <= '0;
         end else if (sending) begin
            stall_q <= stall_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (word_valid) begin
                  // Left-align: shift by 8*(3-n), and 3-n equals ~n for a 2-bit n.
                  shift_q    <= word_data << {~word_bytes_m1, 3'b000};
                  cnt_q      <= word_bytes_m1;
                  stall_q    <= '0;
                  state_q    <= SEND;
                  word_ready <= 1'b0;
                  busy       <= 1'b1;
`ifdef RESPONSE_CHECKSUM_EN
                  xor_q      <= '0;
`endif
               end
            end
            SEND: begin
               if (uart_write) begin
                  shift_q <= shift_q << 8;
                  cnt_q   <= cnt_q - 1'b1;
`ifdef RESPONSE_CHECKSUM_EN
                  xor_q   <= xor_q ^ uart_data;
                  if (cnt_q == 2'd0) begin
                     state_q <= CHKSUM;
                  end
`else
                  if (cnt_q == 2'd0) begin
                     state_q     <= IDLE;
                     word_ready  <= 1'b1;
                     busy        <= 1'b0;
                     frame_count <= frame_count + 1'b1;
                  end
`endif
               end else if (timeout) begin
                  state_q     <= IDLE;
                  word_ready  <= 1'b1;
                  busy        <= 1'b0;
                  stall_error <= 1'b1;
                  stall_q     <= '0;
               end
            end
            CHKSUM: begin
               if (uart_write) begin
                  state_q     <= IDLE;
                  word_ready  <= 1'b1;
                  busy        <= 1'b0;
                  frame_count <= frame_count + 1'b1;
               end else if (timeout) begin
                  state_q     <= IDLE;
                  word_ready  <= 1'b1;
                  busy        <= 1'b0;
                  stall_error <= 1'b1;
                  stall_q     <= '0;
               end
            end
            default: begin
               state_q    <= IDLE;
               word_ready <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_response_serializer.sv
// Bench for uart_response_serializer: directed frames, stall/timeout, mid-frame reset and random frames
// checked against a byte-list reference model.
module tb_uart_response_serializer;
   localparam int TO = 8;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          word_valid;
   logic          word_ready;
   logic [31:0]   word_data;
   logic [1:0]    word_bytes_m1;
   logic          uart_tx_full;
   logic          uart_write;
   logic [7:0]    uart_data;
   logic          busy;
   logic          stall_error;
   logic          error_clear;
   logic [CW-1:0] frame_count;

   int            vectors = 0;
   int            miscompares = 0;
   logic [7:0]    cap[$];
   bit            mon_en = 0;
   logic [CW-1:0] fc_exp;

   uart_response_serializer #(.STALL_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .word_valid(word_valid), .word_ready(word_ready),
      .word_data(word_data), .word_bytes_m1(word_bytes_m1), .uart_tx_full(uart_tx_full),
      .uart_write(uart_write), .uart_data(uart_data), .busy(busy), .stall_error(stall_error),
      .error_clear(error_clear), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte capture on the FIFO side, plus the write-qualification rules.
   always @(negedge clk) begin
      if (mon_en) begin
         if (uart_write === 1'b1) cap.push_back(uart_data);
         if (uart_tx_full) check("write_while_full", uart_write, 0);
         if (!busy) check("write_while_idle", uart_write, 0);
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_word_ready"}, word_ready, 1);
      check({tag, "_uart_write"}, uart_write, 0);
      check({tag, "_uart_data"}, uart_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_stall_error"}, stall_error, 0);
      check({tag, "_frame_count"}, frame_count, 0);
   endtask

   // Entered and left at posedge+1. Junk word_valid is offered while busy and must be ignored.
   task automatic run_frame(input logic [31:0] d, input logic [1:0] n,
                            input int stall_after, input int stall_len, input int rnd_pct);
      logic [7:0] exp_q[$];
      logic [7:0] x;
      logic       full;
      int         base, cyc, fulls, run, left;
      x = 8'h00;
      for (int i = int'(n); i >= 0; i--) begin
         exp_q.push_back(d[8*i +: 8]);
         x = x ^ d[8*i +: 8];
      end
`ifdef RESPONSE_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      word_valid = 1'b1; word_data = d; word_bytes_m1 = n; uart_tx_full = 1'b0;
      @(negedge clk);
      check("accept_word_ready", word_ready, 1);
      @(posedge clk); #1;
      base = cap.size();
      word_valid = 1'b0;
      cyc = 0; fulls = 0; run = 0; left = stall_len;
      forever begin
         if (cap.size() - base == stall_after && left > 0) begin
            full = 1'b1; left--;
         end else begin
            full = (run < 6) && ($urandom_range(0, 99) < rnd_pct);
         end
         run = full ? run + 1 : 0;
         uart_tx_full = full;
         @(negedge clk);
         if (!busy || cyc >= 300) break;
         cyc++;
         if (full) fulls++;
         @(posedge clk); #1;
         word_valid = 1'($urandom_range(0, 1));
         word_data = $urandom;
         word_bytes_m1 = 2'($urandom_range(0, 3));
      end
      word_valid = 1'b0; uart_tx_full = 1'b0;
      #1;
      fc_exp = fc_exp + 1'b1;
      check("frame_bounded", cyc < 300, 1);
      check("busy_cycles", cyc, exp_q.size() + fulls);
      check("byte_count", cap.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < cap.size()) check("byte_value", cap[base + i], exp_q[i]);
      check("frame_count", frame_count, fc_exp);
      check("ready_after_frame", word_ready, 1);
      check("uart_data_hold", uart_data, exp_q[exp_q.size() - 1]);
      check("no_stall_error", stall_error, 0);
      @(posedge clk); #1;
   endtask

   task automatic run_timeout(input logic [31:0] d, input logic clr_hold);
      int base, cyc;
      word_valid = 1'b1; word_data = d; word_bytes_m1 = 2'd3;
      uart_tx_full = 1'b0; error_clear = clr_hold;
      @(posedge clk); #1;
      base = cap.size();
      word_valid = 1'b0; uart_tx_full = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!busy || cyc >= 100) break;
         cyc++;
         @(posedge clk); #1;
      end
      uart_tx_full = 1'b0;
      #1;
      check("timeout_cycles", cyc, TO);
      check("timeout_stall_error", stall_error, 1);
      check("timeout_frame_count", frame_count, fc_exp);
      check("timeout_no_bytes", cap.size() - base, 0);
      check("timeout_word_ready", word_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_error_after_1", stall_error, !clr_hold);
      @(posedge clk); #1;
      error_clear = 1'b1;
      @(posedge clk); #1;
      error_clear = 1'b0;
      @(negedge clk);
      check("stall_error_cleared", stall_error, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      reset = 1'b1; word_valid = 1'b0; word_data = '0; word_bytes_m1 = '0;
      uart_tx_full = 1'b0; error_clear = 1'b0; fc_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      mon_en = 1;
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;

      run_frame(32'hDEADBEEF, 2'd3, -1, 0, 0);
      run_frame(32'h12345678, 2'd1, -1, 0, 0);
      run_frame(32'hA1B2C3D4, 2'd3, 1, 5, 0);
      run_frame(32'h0BADF00D, 2'd2, 0, TO - 1, 0);
      run_frame(32'h01020304, 2'd3, -1, 0, 0);

      run_timeout(32'h11223344, 1'b0);
      run_timeout(32'h55667788, 1'b1);

      // Reset after two of four bytes; the third cycle is held off by tx_full.
      word_valid = 1'b1; word_data = 32'hCAFEF00D; word_bytes_m1 = 2'd3; uart_tx_full = 1'b0;
      @(posedge clk); #1;
      word_valid = 1'b0;
      base = cap.size();
      @(posedge clk); #1;
      @(posedge clk); #1;
      uart_tx_full = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; uart_tx_full = 1'b0;
      fc_exp = '0;
      @(negedge clk);
      #1;
      check_reset_vals("midreset");
      check("midreset_bytes", cap.size() - base, 2);
      if (cap.size() - base >= 2) begin
         check("midreset_b0", cap[base], 8'hCA);
         check("midreset_b1", cap[base + 1], 8'hFE);
      end
      @(posedge clk); #1;
      run_frame(32'h00000055, 2'd0, -1, 0, 0);

      for (int f = 0; f < 24; f++)
         run_frame($urandom, 2'($urandom_range(0, 3)), -1, 0, 35);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_response_serializer.md
Name: uart_response_serializer

Overview:
Transmit-side counterpart of the controller's UART command interpreter. Accepts one response word (ALU result, register or memory read data) per handshake and serializes 1-4 bytes, most-significant byte first, into the UART TX FIFO. It respects FIFO back-pressure, aborts on a prolonged stall, and counts completed frames for debug.

Parameters:
STALL_TIMEOUT, 1023, consecutive cycles of uart_tx_full in SEND before the frame is aborted; 0 disables the timeout.
COUNT_WIDTH, 16, width of frame_count.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
word_valid  input  1  response word offered
word_ready  output  1  serializer can accept a word
word_data  input  32  response payload
word_bytes_m1  input  2  bytes to send minus one (0 means 1 byte, 3 means 4 bytes)
uart_tx_full  input  1  TX FIFO cannot accept a byte this cycle
uart_write  output  1  TX FIFO write strobe
uart_data  output  8  byte written to the TX FIFO
busy  output  1  frame in progress
stall_error  output  1  sticky flag: a frame was aborted by timeout
error_clear  input  1  clears stall_error
frame_count  output  COUNT_WIDTH  number of frames completed since reset

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset values: state IDLE, word_ready=1, uart_write=0, uart_data=0, busy=0, stall_error=0, frame_count=0, byte counter=0, stall counter=0.
- States: IDLE, SEND, plus CHKSUM when the optional feature is enabled.
- IDLE:
  - word_ready=1.
  - On word_valid&&word_ready, latch word_data into the shift register and left-align it so the MSB of the selected bytes is byte 0.
  - Bytes sent for word_bytes_m1=n are word_data[8*(n+1)-1:0], MSB first. Example: n=1 sends word_data[15:8] then word_data[7:0].
  - Latch the remaining-byte counter as n and go to SEND. busy=1 from the next cycle.
- SEND:
  - word_ready=0.
  - uart_write = !uart_tx_full (combinational). uart_data = shift_reg[31:24] (combinational from the register).
  - On each cycle with uart_write=1: shift left by 8, clear the stall counter, and decrement the remaining-byte counter.
  - When the last byte is written, go to IDLE (or CHKSUM if enabled) and increment frame_count, which wraps modulo 2^COUNT_WIDTH.
  - Throughput: 1 byte per cycle with no back-pressure. A 4-byte frame occupies SEND for exactly 4 cycles.
- Back-pressure:
  - While uart_tx_full=1, hold state and shift register; uart_write=0.
  - The stall counter increments each such cycle.
  - If STALL_TIMEOUT!=0 and the counter reaches STALL_TIMEOUT: abort to IDLE, set stall_error=1, leave frame_count unchanged, and drop the remaining bytes.
- stall_error:
  - Cleared by error_clear.
  - If a set and error_clear occur in the same cycle, set wins.
- Latency: word accepted at edge k → first uart_write asserted in cycle k+1 (if not full).
- A new word may be accepted in the cycle after the frame's last byte (IDLE re-entry). There is no back-to-back accept in the last SEND cycle.
- uart_data outside SEND/CHKSUM holds its last value; only uart_write qualifies it.
- word_valid while busy is ignored (word_ready=0); the offering side must hold it.
- Reset mid-frame: immediate return to reset values. Bytes already written stay in the FIFO; the remaining bytes are dropped.

Optional Feature:
RESPONSE_CHECKSUM_EN
- Defined:
  - A running XOR of all data bytes is initialized to 0 on accept.
  - After the last data byte, state CHKSUM writes the XOR byte using the same back-pressure and stall rules.
  - frame_count increments only when the checksum byte is written.
- Undefined: no CHKSUM state and no extra byte; the frame ends after the data bytes.

Test Plan:
- Reset, word_data=0xDEADBEEF, word_bytes_m1=3, tx_full=0 → uart_write high 4 consecutive cycles with bytes DE,AD,BE,EF; frame_count=1; word_ready high again the next cycle.
- word_data=0x12345678, word_bytes_m1=1 → bytes 56,78 only; busy for 2 cycles.
- 0xA1B2C3D4, 4 bytes, tx_full forced high for 5 cycles after the first byte → byte order A1,B2,C3,D4 intact; uart_write never asserted while full.
- STALL_TIMEOUT=8, tx_full held high after accept → abort after 8 cycles; stall_error=1; frame_count unchanged; error_clear pulse → stall_error=0.
- Assert reset after 2 of 4 bytes → outputs at reset values the next cycle; a new word of 0x00000055 with 1 byte → single byte 55.
- With RESPONSE_CHECKSUM_EN: 0x01020304, 4 bytes → bytes 01,02,03,04,04 (XOR=0x04); frame_count increments after the fifth byte.
